// File: rtl/affine_seq.sv
// Forward S-box affine sequencer: time-shares a single-bit affine unit over
// eight issue cycles and assembles the returned bits into one output byte.
module affine_seq #(
  parameter int UNIT_LATENCY = 1,
  parameter int IDX_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [IDX_W-1:0] unit_idx,
  output logic [7:0]       unit_data,
  input  logic             unit_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  state_t                             r_state, w_state_nxt;
  logic [IDX_W-1:0]                   r_idx;
  logic [7:0]                         r_data, r_collect, r_out;
  logic [UNIT_LATENCY-1:0]            r_tag_vld;
  logic [UNIT_LATENCY-1:0][IDX_W-1:0] r_tag_idx;

  logic             w_accept, w_issue, w_cap, w_last_cap;
  logic [IDX_W-1:0] w_cap_idx;
  logic [7:0]       w_collect_nxt;

  assign w_issue    = (r_state == ISSUE);
  assign busy       = (r_state == ISSUE) || (r_state == DRAIN);
  assign out_valid  = (r_state == DONE);
  assign w_accept   = in_valid && in_ready;
  // The oldest tag names the bit the unit is returning this cycle.
  assign w_cap      = r_tag_vld[UNIT_LATENCY-1] && busy;
  assign w_cap_idx  = r_tag_idx[UNIT_LATENCY-1];
  assign w_last_cap = w_cap && (w_cap_idx == LAST_IDX);

  assign unit_idx  = r_idx;
  assign unit_data = r_data;
  assign out_data  = r_out;

  always_comb begin
    w_collect_nxt = r_collect;
    if (w_cap) w_collect_nxt[w_cap_idx] = unit_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ISSUE;
      end
      ISSUE: if (r_idx == LAST_IDX) w_state_nxt = DRAIN;
      DRAIN: if (w_last_cap) w_state_nxt = DONE;
      DONE: begin
        // Result leaving and a new byte arriving can share one cycle.
        in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_data    <= '0;
      r_collect <= '0;
      r_out     <= '0;
    end else begin
      r_collect <= w_collect_nxt;
      if (w_accept) begin
        r_data    <= in_data;
        r_collect <= '0;
        r_idx     <= '0;
      end else if (w_issue && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + 1'b1;
      end else if ((r_state == DONE) && out_ready) begin
        r_idx <= '0;
      end
      if ((r_state == DRAIN) && w_last_cap) r_out <= w_collect_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_idx[0] <= r_idx;
      for (int i = 1; i < UNIT_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end
endmodule
